mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares the core's single memory port between the fetch stage (instruction reads) and the load/store stage (data reads and writes). Data accesses have fixed priority, with a starvation limit that guarantees forward progress for fetch. The block sequences one memory transaction at a time over a req/ack handshake. It also generates the stall signals for fetch and load/store and drops fetch results that are invalidated by a pipeline flush.

Parameters:
ADDR_W, 64, address width of all ports
DATA_W, 64, data width of all ports
STARVE_LIMIT, 4, consecutive data grants allowed while an instruction read is waiting (legal range 1..15)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous, active-low reset
flush_in  in  1  pipeline flush; discard any in-flight instruction result
instr_read_in  in  1  fetch requests an instruction read; held until instr_valid_out
instr_address_in  in  ADDR_W  instruction address
instr_read_value_out  out  DATA_W  instruction data; valid when instr_valid_out=1
instr_valid_out  out  1  one-cycle completion pulse to fetch
data_read_in  in  1  load request; held until data_valid_out
data_write_in  in  1  store request; held until data_valid_out
data_address_in  in  ADDR_W  data address
data_write_value_in  in  DATA_W  store data
data_write_mask_in  in  DATA_W/8  store byte enables
data_read_value_out  out  DATA_W  load data; valid when data_valid_out=1
data_valid_out  out  1  one-cycle completion pulse to load/store
mem_req_out  out  1  memory request; held high until mem_ack_in
mem_write_out  out  1  1 = write, 0 = read
mem_address_out  out  ADDR_W  registered address
mem_write_value_out  out  DATA_W  registered store data
mem_write_mask_out  out  DATA_W/8  registered byte enables
mem_ack_in  in  1  memory completes the request this cycle
mem_read_value_in  in  DATA_W  read data; sampled when mem_ack_in=1
stall_fetch_out  out  1  instr_read_in & ~instr_valid_out (combinational)
stall_mem_out  out  1  (data_read_in | data_write_in) & ~data_valid_out (combinational)

Behaviour:
- States: IDLE, IBUSY, DBUSY, RESP. Reset: IDLE; all registered outputs 0; starve_cnt=0; discard=0.
- Arbitration happens in IDLE only:
  - Data grant: data request present AND (starve_cnt<STARVE_LIMIT OR instr_read_in=0). Go to DBUSY.
  - Instruction grant: otherwise, if instr_read_in=1. Go to IBUSY.
  - Otherwise stay in IDLE.
- On grant: at the same edge, latch the request's address/value/mask into the mem_* registers and set mem_req_out=1. Set mem_write_out=data_write_in for a data grant, 0 for an instruction grant.
- data_read_in and data_write_in both high: treated as a write.
- Starvation counter:
  - Data grant with instr_read_in=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - Instruction grant, or data grant with instr_read_in=0: starve_cnt=0.
- IBUSY/DBUSY: mem_req_out and the mem_* registers are held stable until mem_ack_in=1. On that edge:
  - mem_req_out<=0, then go to RESP.
  - Capture mem_read_value_in into the granted requester's value register (reads only; on a write, data_read_value_out is unchanged).
  - Set the granted requester's valid register to 1.
- RESP: exactly one cycle. The valid output is high and requests are ignored. Next state IDLE, valid cleared. Minimum latency from request to valid is 3 cycles (grant, ack same cycle, resp). Throughput is one transaction per 3 cycles at best.
- mem_ack_in outside IBUSY/DBUSY is ignored.
- Flush:
  - flush_in=1 in IBUSY, or in the ack edge's cycle, sets discard. The transaction still completes on the bus, but instr_valid_out stays 0 in RESP and instr_read_value_out is unchanged.
  - discard is cleared on entry to IDLE.
  - flush_in in IDLE or DBUSY has no effect. flush_in in RESP after an instruction transaction suppresses that cycle's instr_valid_out.
- Value outputs hold their last captured data between completions.
- Asynchronous reset mid-transaction: immediate return to IDLE with mem_req_out=0. The memory must tolerate an abandoned request. No valid pulse is produced for the aborted access.

Test Plan:
- Instruction-only: instr_read_in=1, addr 0x1000; memory acks 2 cycles after mem_req_out rises with 0xDEAD_BEEF -> mem_address_out=0x1000, mem_write_out=0; instr_valid_out pulses once with 0xDEAD_BEEF; stall_fetch_out is high until that cycle.
- Simultaneous: instr and data read both held, memory acks immediately -> data is served first (starve_cnt=1), then the instruction is served, each completion 3 cycles apart.
- Starvation: data requests held continuously, instr held, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 instruction grant, then starve_cnt=0 and data resumes.
- Store: data_write_in=1, value 0x0123_4567_89AB_CDEF, mask 0x0F -> mem_write_out=1, mask 0x0F; data_valid_out pulses; data_read_value_out is unchanged.
- Flush: flush_in pulsed in IBUSY before ack -> no instr_valid_out pulse; the next instruction read completes normally.
- Reset: rst_n low while in DBUSY with mem_req_out=1 -> mem_req_out=0 immediately, state IDLE, no data_valid_out pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction fetch and load/store,
//            with data priority bounded by a starvation limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_in,
    input  logic                instr_read_in,
    input  logic [ADDR_W-1:0]   instr_address_in,
    output logic [DATA_W-1:0]   instr_read_value_out,
    output logic                instr_valid_out,
    input  logic                data_read_in,
    input  logic                data_write_in,
    input  logic [ADDR_W-1:0]   data_address_in,
    input  logic [DATA_W-1:0]   data_write_value_in,
    input  logic [DATA_W/8-1:0] data_write_mask_in,
    output logic [DATA_W-1:0]   data_read_value_out,
    output logic                data_valid_out,
    output logic                mem_req_out,
    output logic                mem_write_out,
    output logic [ADDR_W-1:0]   mem_address_out,
    output logic [DATA_W-1:0]   mem_write_value_out,
    output logic [DATA_W/8-1:0] mem_write_mask_out,
    input  logic                mem_ack_in,
    input  logic [DATA_W-1:0]   mem_read_value_in,
    output logic                stall_fetch_out,
    output logic                stall_mem_out
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IBUSY = 2'd1,
        S_DBUSY = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_starve_cnt;
    logic       r_discard;
    logic       r_instr_valid;

    logic w_data_req;
    logic w_data_grant;

    assign w_data_req   = data_read_in | data_write_in;
    assign w_data_grant = w_data_req & ((r_starve_cnt < c_starve_limit) | ~instr_read_in);

    // A flush during the response cycle still kills the fetch completion.
    assign instr_valid_out = r_instr_valid & ~flush_in;
    assign stall_fetch_out = instr_read_in & ~instr_valid_out;
    assign stall_mem_out   = w_data_req & ~data_valid_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state              <= S_IDLE;
            r_starve_cnt         <= 4'd0;
            r_discard            <= 1'b0;
            r_instr_valid        <= 1'b0;
            instr_read_value_out <= '0;
            data_read_value_out  <= '0;
            data_valid_out       <= 1'b0;
            mem_req_out          <= 1'b0;
            mem_write_out        <= 1'b0;
            mem_address_out      <= '0;
            mem_write_value_out  <= '0;
            mem_write_mask_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_discard <= 1'b0;
                    if (w_data_grant) begin
                        r_state             <= S_DBUSY;
                        mem_req_out         <= 1'b1;
                        mem_write_out       <= data_write_in;
                        mem_address_out     <= data_address_in;
                        mem_write_value_out <= data_write_value_in;
                        mem_write_mask_out  <= data_write_mask_in;
                        if (instr_read_in) begin
                            if (r_starve_cnt < c_starve_limit) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                        end else begin
                            r_starve_cnt <= 4'd0;
                        end
                    end else if (instr_read_in) begin
                        r_state             <= S_IBUSY;
                        mem_req_out         <= 1'b1;
                        mem_write_out       <= 1'b0;
                        mem_address_out     <= instr_address_in;
                        mem_write_value_out <= '0;
                        mem_write_mask_out  <= '0;
                        r_starve_cnt        <= 4'd0;
                    end
                end
                S_IBUSY: begin
                    if (flush_in) begin
                        r_discard <= 1'b1;
                    end
                    if (mem_ack_in) begin
                        mem_req_out <= 1'b0;
                        r_state     <= S_RESP;
                        // Flushed fetches finish on the bus but never reach fetch.
                        if (!(r_discard || flush_in)) begin
                            instr_read_value_out <= mem_read_value_in;
                            r_instr_valid        <= 1'b1;
                        end
                    end
                end
                S_DBUSY: begin
                    if (mem_ack_in) begin
                        mem_req_out    <= 1'b0;
                        r_state        <= S_RESP;
                        data_valid_out <= 1'b1;
                        if (!mem_write_out) begin
                            data_read_value_out <= mem_read_value_in;
                        end
                    end
                end
                S_RESP: begin
                    r_state        <= S_IDLE;
                    r_instr_valid  <= 1'b0;
                    data_valid_out <= 1'b0;
                    r_discard      <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
